// File: rtl/posit_acc_seq.sv
// Accumulation controller around an external combinational posit adder.
// Streams operands in, folds them into a running sum, and emits the sum on the last operand.
module posit_acc_seq #(
  parameter int N  = 16,
  parameter int es = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [N-1:0]  add_in1,
  output logic [N-1:0]  add_in2,
  output logic          add_start,
  input  logic [N-1:0]  add_out,
  input  logic          add_inf,
  input  logic          add_zero,
  input  logic          add_done,
  output logic [N-1:0]  out_data,
  output logic          out_inf,
  output logic [CW-1:0] out_cnt,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {S_IN, S_ADD, S_OUT} state_t;

  state_t        state;
  logic [N-1:0]  acc;
  logic [N-1:0]  op_r;
  logic          last_r;
  logic          inf_r;
  logic [CW-1:0] cnt;

  // A zero sum is already encoded in the adder's result word.
  logic unused_zero;
  assign unused_zero = add_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IN;
      acc    <= '0;
      op_r   <= '0;
      last_r <= 1'b0;
      inf_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IN: begin
          if (in_valid) begin
            op_r   <= in_data;
            last_r <= in_last;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          if (add_done) begin
            acc   <= add_out;
            inf_r <= inf_r | add_inf;
            if (cnt != {CW{1'b1}})
              cnt <= cnt + 1'b1;
            state <= last_r ? S_OUT : S_IN;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            acc   <= '0;
            inf_r <= 1'b0;
            cnt   <= '0;
            state <= S_IN;
          end
        end
        default: state <= S_IN;
      endcase
    end
  end

  // Handshake outputs depend on the state register only, never on inputs.
  assign in_ready  = (state == S_IN);
  assign add_start = (state == S_ADD);
  assign out_valid = (state == S_OUT);

  assign add_in1  = acc;
  assign add_in2  = op_r;
  assign out_data = acc;
  assign out_inf  = inf_r;
  assign out_cnt  = cnt;

endmodule
